// File: rtl/ram_fifo_if.sv
// ---------------------------------------------------------------------------
// ram_fifo_if
// Purpose : bundles the producer/consumer handshake, the status outputs and
//           the peek port of ram_fifo into one interface.
// Signals : enq, din, deq          - enqueue/dequeue requests and enqueue data
//           dout                   - head entry (0 when empty)
//           full, empty, count     - occupancy status
//           ovf, udf               - one-cycle reject pulses
//           peek_addr, peek_data   - non-destructive read at head+offset
//           almost_full/empty      - only when RAM_FIFO_ALMOST_EN is defined
// Modports: master (producer/consumer side), slave (the FIFO itself).
// ---------------------------------------------------------------------------
interface ram_fifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) ();
    logic              enq;
    logic [DATA_W-1:0] din;
    logic              deq;
    logic [DATA_W-1:0] dout;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              ovf;
    logic              udf;
    logic [ADDR_W-1:0] peek_addr;
    logic [DATA_W-1:0] peek_data;
`ifdef RAM_FIFO_ALMOST_EN
    logic              almost_full;
    logic              almost_empty;

    modport master (
        output enq, din, deq, peek_addr,
        input  dout, full, empty, count, ovf, udf, peek_data,
        input  almost_full, almost_empty
    );

    modport slave (
        input  enq, din, deq, peek_addr,
        output dout, full, empty, count, ovf, udf, peek_data,
        output almost_full, almost_empty
    );
`else
    modport master (
        output enq, din, deq, peek_addr,
        input  dout, full, empty, count, ovf, udf, peek_data
    );

    modport slave (
        input  enq, din, deq, peek_addr,
        output dout, full, empty, count, ovf, udf, peek_data
    );
`endif
endinterface

// File: rtl/ram_fifo.sv
// ---------------------------------------------------------------------------
// ram_fifo
// Purpose : parametrised first-word-fall-through queue on a RAM array with
//           synchronous writes and asynchronous reads. One enqueue and one
//           dequeue may be accepted per cycle. A peek port reads the entry
//           at head+offset through a registered address (one-cycle latency).
// Ports   : clk        - clock, rising edge active
//           rst_n      - asynchronous active-low reset
//           bus        - ram_fifo_if.slave (enq/din/deq, dout, full, empty,
//                        count, ovf, udf, peek_addr, peek_data)
// Options : define RAM_FIFO_ALMOST_EN to add almost_full (count >= AF_LVL)
//           and almost_empty (count <= AE_LVL) to the interface; the AF_LVL
//           and AE_LVL parameters exist only in that build.
// ---------------------------------------------------------------------------
module ram_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
`ifdef RAM_FIFO_ALMOST_EN
    ,
    parameter int AF_LVL = (1 << ADDR_W) - 2,
    parameter int AE_LVL = 1
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    ram_fifo_if.slave   bus
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [ADDR_W-1:0] r_wrPtr;
    logic [ADDR_W-1:0] r_rdPtr;
    logic [ADDR_W-1:0] r_peekAddr;
    logic [ADDR_W:0]   r_count;
    logic              r_ovf;
    logic              r_udf;

    logic              w_full;
    logic              w_empty;
    logic              w_enqOk;
    logic              w_deqOk;

    // Status flags come from the occupancy count so that the full and empty
    // cases stay distinct even though the pointers are equal in both.
    assign w_full  = (r_count == (ADDR_W+1)'(DEPTH));
    assign w_empty = (r_count == '0);

    // A full queue still accepts an enqueue when a dequeue frees a slot on
    // the same edge; an empty queue never accepts a dequeue.
    assign w_enqOk = bus.enq & (~w_full | bus.deq);
    assign w_deqOk = bus.deq & ~w_empty;

    // Storage is deliberately not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_enqOk) begin
            r_mem[r_wrPtr] <= bus.din;
        end
    end

    // Pointers, occupancy, reject pulses and the peek address register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_peekAddr <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
        end else begin
            if (w_enqOk) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_deqOk) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_count    <= r_count + (ADDR_W+1)'(w_enqOk) - (ADDR_W+1)'(w_deqOk);
            r_ovf      <= bus.enq & w_full & ~bus.deq;
            r_udf      <= bus.deq & w_empty;
            // Offset is taken from the head as it was before this edge and
            // wraps naturally at the pointer width.
            r_peekAddr <= r_rdPtr + bus.peek_addr;
        end
    end

    // Reads are asynchronous, so a peek of a slot written on the previous
    // edge already returns the new data.
    assign bus.dout      = w_empty ? '0 : r_mem[r_rdPtr];
    assign bus.peek_data = r_mem[r_peekAddr];
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.count     = r_count;
    assign bus.ovf       = r_ovf;
    assign bus.udf       = r_udf;

`ifdef RAM_FIFO_ALMOST_EN
    assign bus.almost_full  = (r_count >= (ADDR_W+1)'(AF_LVL));
    assign bus.almost_empty = (r_count <= (ADDR_W+1)'(AE_LVL));
`endif

endmodule

// File: tb/tb_ram_fifo.sv
// ---------------------------------------------------------------------------
// tb_ram_fifo
// Purpose : directed self-checking bench for ram_fifo with DATA_W=8,
//           ADDR_W=4 (16 entries). Covers asynchronous reset, enqueue and
//           fall-through, peek, fill/overflow, simultaneous enq+deq when
//           full, wrap-around drain, underflow and, when RAM_FIFO_ALMOST_EN
//           is defined, the almost_full/almost_empty thresholds.
// ---------------------------------------------------------------------------
module tb_ram_fifo;

    logic clk;
    logic rst_n;

    int compareCount;
    int failCount;

    ram_fifo_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    ram_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one cycle of requests, lets the edge happen, then returns the
    // request lines to idle 1 time unit after the edge, where outputs are
    // sampled.
    task automatic applyStimulus(input logic e, input logic [7:0] d, input logic q);
        bus.enq = e;
        bus.din = d;
        bus.deq = q;
        @(posedge clk);
        #1;
        bus.enq = 1'b0;
        bus.deq = 1'b0;
    endtask

    // One comparison: counts it, and on a miss counts the failure and reports.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        compareCount  = 0;
        failCount     = 0;
        rst_n         = 1'b0;
        bus.enq       = 1'b0;
        bus.deq       = 1'b0;
        bus.din       = 8'h00;
        bus.peek_addr = 4'd0;

        // Power-on reset.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("por_count", 16'(bus.count), 16'd0);
        checkOutput("por_empty", 16'(bus.empty), 16'd1);
        rst_n = 1'b1;

        // Put something in, then reset between edges and check without an edge.
        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 8'h77, 1'b0);
        applyStimulus(1'b1, 8'h66, 1'b0);
        checkOutput("pre_reset_count", 16'(bus.count), 16'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_count", 16'(bus.count), 16'd0);
        checkOutput("rst_empty", 16'(bus.empty), 16'd1);
        checkOutput("rst_full",  16'(bus.full),  16'd0);
        checkOutput("rst_dout",  16'(bus.dout),  16'h00);
        checkOutput("rst_ovf",   16'(bus.ovf),   16'd0);
        checkOutput("rst_udf",   16'(bus.udf),   16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Three enqueues with fall-through head and peek at offset 2.
        $display("[TB] enqueue 11/22/33 and peek");
        applyStimulus(1'b1, 8'h11, 1'b0);
        checkOutput("enq1_count", 16'(bus.count), 16'd1);
        checkOutput("enq1_dout",  16'(bus.dout),  16'h11);
        applyStimulus(1'b1, 8'h22, 1'b0);
        checkOutput("enq2_count", 16'(bus.count), 16'd2);
        applyStimulus(1'b1, 8'h33, 1'b0);
        checkOutput("enq3_count", 16'(bus.count), 16'd3);
        checkOutput("enq3_dout",  16'(bus.dout),  16'h11);
        bus.peek_addr = 4'd2;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("peek2", 16'(bus.peek_data), 16'h33);
        bus.peek_addr = 4'd0;

        // Drain them; head pointer ends at 3.
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("deq1_dout", 16'(bus.dout), 16'h22);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("deq2_dout", 16'(bus.dout), 16'h33);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("deq3_dout",  16'(bus.dout),  16'h00);
        checkOutput("deq3_empty", 16'(bus.empty), 16'd1);

        // Fill 16 entries 00..0F, starting at slot 3 so the write pointer wraps.
        $display("[TB] fill and overflow");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0);
        end
        checkOutput("fill_count", 16'(bus.count), 16'd16);
        checkOutput("fill_full",  16'(bus.full),  16'd1);
        checkOutput("fill_dout",  16'(bus.dout),  16'h00);
        applyStimulus(1'b1, 8'hAA, 1'b0);
        checkOutput("ovf_pulse", 16'(bus.ovf),   16'd1);
        checkOutput("ovf_count", 16'(bus.count), 16'd16);
        checkOutput("ovf_dout",  16'(bus.dout),  16'h00);
        bus.peek_addr = 4'd15;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("ovf_clear", 16'(bus.ovf),       16'd0);
        checkOutput("peek_tail", 16'(bus.peek_data), 16'h0F);
        bus.peek_addr = 4'd0;

        // Simultaneous enq+deq on a full queue.
        $display("[TB] enq+deq when full, then drain");
        applyStimulus(1'b1, 8'hBB, 1'b1);
        checkOutput("fulled_count", 16'(bus.count), 16'd16);
        checkOutput("fulled_dout",  16'(bus.dout),  16'h01);
        checkOutput("fulled_ovf",   16'(bus.ovf),   16'd0);
        // Queue now holds 01..0F then BB.
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("drain_head%0d", i), 16'(bus.dout),
                        (i < 15) ? 16'(i + 1) : 16'hBB);
            applyStimulus(1'b0, 8'h00, 1'b1);
        end
        checkOutput("drain_count", 16'(bus.count), 16'd0);
        checkOutput("drain_empty", 16'(bus.empty), 16'd1);
        checkOutput("drain_dout",  16'(bus.dout),  16'h00);

        // Underflow cases.
        $display("[TB] underflow");
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("udf_pulse", 16'(bus.udf),   16'd1);
        checkOutput("udf_count", 16'(bus.count), 16'd0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("udf_clear", 16'(bus.udf), 16'd0);
        applyStimulus(1'b1, 8'h5A, 1'b1);
        checkOutput("enqdeq_count", 16'(bus.count), 16'd1);
        checkOutput("enqdeq_dout",  16'(bus.dout),  16'h5A);
        checkOutput("enqdeq_udf",   16'(bus.udf),   16'd1);

`ifdef RAM_FIFO_ALMOST_EN
        // Thresholds AF_LVL=14, AE_LVL=1 (defaults for ADDR_W=4).
        $display("[TB] almost flags");
        checkOutput("ae_at1", 16'(bus.almost_empty), 16'd1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("ae_at0", 16'(bus.almost_empty), 16'd1);
        checkOutput("af_at0", 16'(bus.almost_full),  16'd0);
        for (int n = 1; n <= 16; n++) begin
            applyStimulus(1'b1, 8'(n), 1'b0);
            checkOutput($sformatf("ae_at%0d", n), 16'(bus.almost_empty),
                        (n <= 1) ? 16'd1 : 16'd0);
            checkOutput($sformatf("af_at%0d", n), 16'(bus.almost_full),
                        (n >= 14) ? 16'd1 : 16'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/ram_fifo.md
Name: ram_fifo

Overview:
- Parametrised queue built on a synchronous-write, registered-read-address RAM array; successor to the fixed 16x8 single-port RAM.
- Generalised in data width and depth. Adds a queue mode with read/write pointers, occupancy count, full/empty flags and overflow/underflow pulses.
- Adds a non-destructive peek port for debug and display logic.
- Sits between a producer (switch/button front-end or datapath) and a consumer. One enqueue and one dequeue per cycle.

Parameters:
- DATA_W, 8: width of each entry in bits.
- ADDR_W, 4: pointer width; depth = 2^ADDR_W entries.
- AF_LVL, 2^ADDR_W-2: almost-full threshold; used only with RAM_FIFO_ALMOST_EN.
- AE_LVL, 1: almost-empty threshold; used only with RAM_FIFO_ALMOST_EN.

Ports:
- clk  in  1: clock, rising edge active.
- rst_n  in  1: asynchronous active-low reset.
- enq  in  1: enqueue request, sampled on rising clk.
- din  in  DATA_W: enqueue data.
- deq  in  1: dequeue request, sampled on rising clk.
- dout  out  DATA_W: head entry; 0 when empty.
- full  out  1: count == 2^ADDR_W.
- empty  out  1: count == 0.
- count  out  ADDR_W+1: current occupancy, 0..2^ADDR_W.
- ovf  out  1: one-cycle pulse; enq was rejected because the queue was full (and no deq that cycle).
- udf  out  1: one-cycle pulse; deq was rejected because the queue was empty.
- peek_addr  in  ADDR_W: offset from the head for peek.
- peek_data  out  DATA_W: entry at head+offset, registered-address read.

Behaviour:
- Reset is async on rst_n low:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - empty = 1, full = 0, ovf = 0, udf = 0.
  - peek address register = 0.
  - Memory contents are not reset.
- Reset asserted mid-operation discards all queued entries immediately. After rst_n deasserts, dout = 0 because the queue is empty.
- Storage: reg array [0:2^ADDR_W-1] of DATA_W. Writes are synchronous. Reads are asynchronous from a registered or pointer address.
- Pointers are ADDR_W bits and wrap naturally from 2^ADDR_W-1 to 0. Full/empty come from count, not from pointer compare.
- Accept rules, evaluated on the rising clk edge:
  - enq_ok = enq & (!full | deq).
  - deq_ok = deq & !empty.
  - Note: when empty, deq is rejected, so enq+deq on an empty queue is enq only.
  - When full, enq+deq are both accepted; count is unchanged and wr_ptr/rd_ptr both advance.
- Update on the edge:
  - enq_ok: mem[wr_ptr] <= din; wr_ptr <= wr_ptr+1.
  - deq_ok: rd_ptr <= rd_ptr+1.
  - count <= count + enq_ok - deq_ok.
- Flags:
  - ovf <= enq & full & !deq.
  - udf <= deq & empty.
  - Both are registered, high for exactly one cycle per offending request, and cleared otherwise.
- dout = empty ? 0 : mem[rd_ptr]. This is first-word fall-through: a written entry appears on dout in the cycle after the enqueuing edge.
- Peek:
  - peek_reg <= rd_ptr + peek_addr every edge, mod 2^ADDR_W.
  - peek_data = mem[peek_reg]. Latency is one cycle.
  - Returns stale data when offset >= count; this is not flagged.
- Write-then-peek: peeking the entry written on the same edge returns the new data.
- Latency: enqueue to visible on dout/count is 1 cycle. Dequeue to next head on dout is 1 cycle.

Optional Feature:
- Macro: RAM_FIFO_ALMOST_EN.
- Defined:
  - Adds output ports almost_full (1) and almost_empty (1), both combinational from count.
  - almost_full = count >= AF_LVL.
  - almost_empty = count <= AE_LVL.
  - After reset: almost_full = 0, almost_empty = 1.
- Undefined: neither port exists. AF_LVL and AE_LVL are unused. All other behaviour is identical.

Test Plan (DATA_W=8, ADDR_W=4):
- Reset with rst_n=0 mid-clock:
  - outputs go to count=0, empty=1, full=0, dout=0, ovf=udf=0 without waiting for a clk edge.
  - After release, peek_data is unchecked.
- Enqueue 8'h11, 8'h22, 8'h33 on consecutive edges:
  - count steps 1,2,3; dout=8'h11 from the cycle after the first edge.
  - With peek_addr=2, peek_data=8'h33 one cycle later.
- Fill 16 entries 8'h00..8'h0F:
  - full=1, count=16.
  - A further enq of 8'hAA gives an ovf pulse of 1 cycle, with count and contents unchanged.
- On the full queue, enq 8'hBB and deq together:
  - count stays 16, dout becomes 8'h01, no ovf.
  - After 16 more deqs, the last value out is 8'hBB (wrap-around verified).
- Empty queue:
  - deq alone gives a udf pulse and count stays 0.
  - enq 8'h5A with deq together gives count=1, dout=8'h5A and a udf pulse.
- With RAM_FIFO_ALMOST_EN, AF_LVL=14, AE_LVL=1:
  - almost_empty=1 at count 0 and 1, and 0 at count 2.
  - almost_full=1 at count 14, 15 and 16.
